// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
// Holds the FSM encoding, counter-width derivation and signed-overflow rule.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SA_DEFAULT_WIDTH = 8;

  // Counter must hold 0..WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int SA_DEFAULT_CNT_W = cnt_width(SA_DEFAULT_WIDTH);

  // Two's-complement overflow: carry into the sign bit differs from carry out of it.
  function automatic logic signed_overflow(input logic carry_in_msb, input logic carry_out);
    return carry_in_msb ^ carry_out;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// Single-bit full adder built from two half-adder stages plus an OR of their carries.
// Purely combinational; reusable wherever a one-bit add cell is needed.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign c     = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock, LSB first.
// Operands enter on an in_valid/in_ready handshake; results leave on out_valid/out_ready.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, and the result holds until taken.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s;
  logic fa_c;

  full_adder_bit u_fa (
    .a   (opa_q[0]),
    .b   (opb_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .c   (fa_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so the inverted B and forced carry-in do the work.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cout_d  = fa_c;
          ovf_d   = signed_overflow(carry_q, fa_c);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
